// File: rtl/cam_ctrl_handover_pkg.sv
// Shared types and constants for camera-bus ownership handover.
// Widths are shared with the SCCB master and the auto-config sequencer.
package cam_ctrl_pkg;

  localparam int SCCB_ADDR_W = 8;
  localparam int SCCB_DATA_W = 8;

  localparam logic OWNER_HW   = 1'b0;
  localparam logic OWNER_PROC = 1'b1;

  typedef enum logic [1:0] {
    OWN    = 2'd0,
    DRAIN  = 2'd1,
    SETTLE = 2'd2
  } cam_state_e;

endpackage

// File: rtl/cam_ctrl_handover_if.sv
// Request, SCCB launch and ownership status signals around the handover arbiter.
// slave is the arbiter's view, master is the surrounding system's view.
interface cam_ctrl_handover_if import cam_ctrl_pkg::*; #(
  parameter int ADDR_W = SCCB_ADDR_W,
  parameter int DATA_W = SCCB_DATA_W
);

  logic              proc_has_control;
  logic              proc_req;
  logic [ADDR_W-1:0] proc_addr;
  logic [DATA_W-1:0] proc_wdata;
  logic              proc_ack;
  logic              hw_req;
  logic [ADDR_W-1:0] hw_addr;
  logic [DATA_W-1:0] hw_wdata;
  logic              hw_ack;
  logic              hw_pause;
  logic              sccb_start;
  logic [ADDR_W-1:0] sccb_addr;
  logic [DATA_W-1:0] sccb_wdata;
  logic              sccb_busy;
  logic              sccb_done;
  logic              owner;
  logic              handover_busy;

  modport slave (
    input  proc_has_control, proc_req, proc_addr, proc_wdata,
    input  hw_req, hw_addr, hw_wdata, sccb_busy, sccb_done,
    output proc_ack, hw_ack, hw_pause, sccb_start, sccb_addr, sccb_wdata,
    output owner, handover_busy
  );

  modport master (
    output proc_has_control, proc_req, proc_addr, proc_wdata,
    output hw_req, hw_addr, hw_wdata, sccb_busy, sccb_done,
    input  proc_ack, hw_ack, hw_pause, sccb_start, sccb_addr, sccb_wdata,
    input  owner, handover_busy
  );

endinterface

// File: rtl/cam_ctrl_handover_settle_timer.sv
// Bus settle down-counter: load, decrement, zero flag; holds at zero until reloaded.
// Zero is combinational from the count register.
module cam_settle_timer #(
  parameter int CNT_W    = 5,
  parameter int LOAD_VAL = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(LOAD_VAL);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/cam_ctrl_handover.sv
// Arbitrates camera register writes between Nios and the HW sequencer onto one SCCB master.
// Ownership flips only after the bus drains and a settle period; non-owner requests wait.
module cam_ctrl_handover import cam_ctrl_pkg::*; #(
  parameter int ADDR_W        = SCCB_ADDR_W,
  parameter int DATA_W        = SCCB_DATA_W,
  parameter int SETTLE_CYCLES = 16
) (
  input logic               clk,
  input logic               reset_n,
  cam_ctrl_handover_if.slave bus
);

  localparam logic [1:0] S_OWN    = 2'(OWN);
  localparam logic [1:0] S_DRAIN  = 2'(DRAIN);
  localparam logic [1:0] S_SETTLE = 2'(SETTLE);
  localparam int         CNT_W    = $clog2(SETTLE_CYCLES + 1);

  logic [1:0]        state;
  logic              pc_q;
  logic              owner_q;
  logic              in_flight;
  logic              src_q;
  logic              start_q;
  logic              proc_ack_q;
  logic              hw_ack_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic ack_pending;
  logic owner_req;
  logic issue;
  logic done_hit;
  logic settle_load;
  logic settle_dec;
  logic settle_zero;

  // The ack cycle blocks issue so a requester dropping req on ack is never served twice.
  assign ack_pending = proc_ack_q | hw_ack_q;
  assign owner_req   = (owner_q == OWNER_PROC) ? bus.proc_req : bus.hw_req;
  assign issue       = (state == S_OWN) & owner_req & ~in_flight & ~bus.sccb_busy & ~ack_pending;
  assign done_hit    = bus.sccb_done & in_flight;
  assign settle_load = (state == S_DRAIN) & ~in_flight & ~ack_pending;
  assign settle_dec  = (state == S_SETTLE);

  cam_settle_timer #(
    .CNT_W   (CNT_W),
    .LOAD_VAL(SETTLE_CYCLES - 1)
  ) u_settle_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (settle_load),
    .dec    (settle_dec),
    .zero   (settle_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_OWN;
      owner_q <= OWNER_HW;
    end else begin
      case (state)
        S_OWN: begin
          if (pc_q != owner_q) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (settle_load) state <= S_SETTLE;
        end
        S_SETTLE: begin
          // pc_q may have reverted during settle; owner then stays as it was.
          if (settle_zero) begin
            state   <= S_OWN;
            owner_q <= pc_q;
          end
        end
        default: state <= S_OWN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q       <= 1'b0;
      in_flight  <= 1'b0;
      src_q      <= OWNER_HW;
      start_q    <= 1'b0;
      proc_ack_q <= 1'b0;
      hw_ack_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      pc_q       <= bus.proc_has_control;
      start_q    <= issue;
      proc_ack_q <= done_hit & (src_q == OWNER_PROC);
      hw_ack_q   <= done_hit & (src_q == OWNER_HW);
      if (issue) begin
        in_flight <= 1'b1;
        src_q     <= owner_q;
        addr_q    <= (owner_q == OWNER_PROC) ? bus.proc_addr  : bus.hw_addr;
        wdata_q   <= (owner_q == OWNER_PROC) ? bus.proc_wdata : bus.hw_wdata;
      end else if (done_hit) begin
        in_flight <= 1'b0;
      end
    end
  end

  assign bus.sccb_start    = start_q;
  assign bus.sccb_addr     = addr_q;
  assign bus.sccb_wdata    = wdata_q;
  assign bus.proc_ack      = proc_ack_q;
  assign bus.hw_ack        = hw_ack_q;
  assign bus.owner         = owner_q;
  assign bus.handover_busy = (state != S_OWN);
  assign bus.hw_pause      = owner_q | (state != S_OWN);

endmodule

// File: tb/tb_cam_ctrl_handover.sv
// Bench for cam_ctrl_handover: vector table, handover sequences and random traffic
// compared cycle by cycle against a behavioural model.
module tb_cam_ctrl_handover;

  localparam int SETTLE = 16;
  localparam int M_OWN = 0, M_DRAIN = 1, M_SETTLE = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  cam_ctrl_handover_if bus ();

  cam_ctrl_handover #(
    .ADDR_W       (8),
    .DATA_W       (8),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic       pc;
    logic       proc_req;
    logic [7:0] proc_addr;
    logic [7:0] proc_wdata;
    logic       hw_req;
    logic [7:0] hw_addr;
    logic [7:0] hw_wdata;
    logic       busy;
    logic       done;
  } in_t;

  typedef struct packed {
    logic       start;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       proc_ack;
    logic       hw_ack;
    logic       hw_pause;
    logic       owner;
    logic       hbusy;
  } out_t;

  typedef struct {
    in_t  i;
    out_t e;
  } vec_t;

  int checks = 0;
  int failures = 0;
  in_t cur;
  int sccb_rem = 0;

  // Behavioural model: ownership, one outstanding transaction, pending ack, settle countdown.
  bit m_pc, m_owner, m_src, m_inflight, m_start, m_ackp, m_ackh;
  int m_mode, m_left;
  logic [7:0] m_addr, m_wdata;

  function automatic void model_reset();
    m_pc = 0; m_owner = 0; m_src = 0; m_inflight = 0; m_start = 0;
    m_ackp = 0; m_ackh = 0; m_mode = M_OWN; m_left = 0;
    m_addr = 8'h00; m_wdata = 8'h00;
  endfunction

  function automatic void model_step(input in_t x);
    bit ack_pend = m_ackp | m_ackh;
    bit own_pre  = m_owner;
    bit want     = own_pre ? x.proc_req : x.hw_req;
    bit fire     = (m_mode == M_OWN) && want && !m_inflight && !x.busy && !ack_pend;
    bit fin      = x.done && m_inflight;
    case (m_mode)
      M_OWN:   if (m_pc != own_pre) m_mode = M_DRAIN;
      M_DRAIN: if (!m_inflight && !ack_pend) begin m_mode = M_SETTLE; m_left = SETTLE; end
      default: begin
        m_left = m_left - 1;
        if (m_left == 0) begin m_mode = M_OWN; m_owner = m_pc; end
      end
    endcase
    m_ackp  = fin && m_src;
    m_ackh  = fin && !m_src;
    m_start = fire;
    if (fire) begin
      m_inflight = 1;
      m_src      = own_pre;
      m_addr     = own_pre ? x.proc_addr  : x.hw_addr;
      m_wdata    = own_pre ? x.proc_wdata : x.hw_wdata;
    end else if (fin) begin
      m_inflight = 0;
    end
    m_pc = x.pc;
  endfunction

  function automatic out_t mdl_out();
    out_t o;
    o.start = m_start; o.addr = m_addr; o.wdata = m_wdata;
    o.proc_ack = m_ackp; o.hw_ack = m_ackh;
    o.hbusy = (m_mode != M_OWN);
    o.hw_pause = m_owner | (m_mode != M_OWN);
    o.owner = m_owner;
    return o;
  endfunction

  function automatic out_t dut_out();
    out_t o;
    o.start = bus.sccb_start; o.addr = bus.sccb_addr; o.wdata = bus.sccb_wdata;
    o.proc_ack = bus.proc_ack; o.hw_ack = bus.hw_ack; o.hw_pause = bus.hw_pause;
    o.owner = bus.owner; o.hbusy = bus.handover_busy;
    return o;
  endfunction

  function automatic in_t mk_in(logic pc, logic preq, logic [7:0] pa, logic [7:0] pd,
                                logic hreq, logic [7:0] ha, logic [7:0] hd, logic busy, logic done);
    in_t v;
    v.pc = pc; v.proc_req = preq; v.proc_addr = pa; v.proc_wdata = pd;
    v.hw_req = hreq; v.hw_addr = ha; v.hw_wdata = hd; v.busy = busy; v.done = done;
    return v;
  endfunction

  function automatic out_t mk_out(logic st, logic [7:0] a, logic [7:0] d, logic pack,
                                  logic hack, logic pause, logic own, logic hb);
    out_t o;
    o.start = st; o.addr = a; o.wdata = d; o.proc_ack = pack; o.hw_ack = hack;
    o.hw_pause = pause; o.owner = own; o.hbusy = hb;
    return o;
  endfunction

  task automatic check_out(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual start=%0b addr=%02h wdata=%02h proc_ack=%0b hw_ack=%0b hw_pause=%0b owner=%0b handover_busy=%0b | required start=%0b addr=%02h wdata=%02h proc_ack=%0b hw_ack=%0b hw_pause=%0b owner=%0b handover_busy=%0b",
               name, act.start, act.addr, act.wdata, act.proc_ack, act.hw_ack, act.hw_pause, act.owner, act.hbusy,
               exp.start, exp.addr, exp.wdata, exp.proc_ack, exp.hw_ack, exp.hw_pause, exp.owner, exp.hbusy);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic apply();
    bus.proc_has_control = cur.pc;
    bus.proc_req = cur.proc_req; bus.proc_addr = cur.proc_addr; bus.proc_wdata = cur.proc_wdata;
    bus.hw_req = cur.hw_req; bus.hw_addr = cur.hw_addr; bus.hw_wdata = cur.hw_wdata;
    bus.sccb_busy = cur.busy; bus.sccb_done = cur.done;
  endtask

  task automatic tick();
    apply();
    @(posedge clk);
    if (reset_n) model_step(cur);
    #1;
    check_out("cycle", dut_out(), mdl_out());
  endtask

  // SCCB master stand-in: busy for a random time after each start, then one done pulse.
  task automatic gen_sccb(input bit spurious);
    cur.done = 1'b0;
    if (bus.sccb_start) sccb_rem = $urandom_range(1, 4);
    if (sccb_rem > 0) begin
      sccb_rem--;
      if (sccb_rem == 0) begin cur.busy = 1'b0; cur.done = 1'b1; end
      else cur.busy = 1'b1;
    end else begin
      cur.busy = 1'b0;
      if (spurious && $urandom_range(0, 49) == 0) cur.done = 1'b1;
    end
  endtask

  task automatic gen_req(input bit rnd_hw, input bit rnd_proc);
    if (rnd_proc) begin
      if (bus.proc_ack) cur.proc_req = 1'b0;
      if (!cur.proc_req && $urandom_range(0, 3) == 0) begin
        cur.proc_req = 1'b1; cur.proc_addr = 8'($urandom); cur.proc_wdata = 8'($urandom);
      end
    end
    if (rnd_hw) begin
      if (bus.hw_ack) cur.hw_req = 1'b0;
      if (!cur.hw_req && $urandom_range(0, 3) == 0) begin
        cur.hw_req = 1'b1; cur.hw_addr = 8'($urandom); cur.hw_wdata = 8'($urandom);
      end
    end
  endtask

  task automatic run_auto(input int n, input bit rnd_pc, input bit rnd_hw, input bit rnd_proc,
                          output int pa, output int ha);
    pa = 0; ha = 0;
    for (int i = 0; i < n; i++) begin
      gen_sccb(rnd_pc);
      gen_req(rnd_hw, rnd_proc);
      if (rnd_pc && $urandom_range(0, 79) == 0) cur.pc = ~cur.pc;
      tick();
      if (bus.proc_ack) pa++;
      if (bus.hw_ack) ha++;
    end
  endtask

  task automatic wait_start(input string name, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (bus.sccb_start) seen = 1'b1;
    end
    check_int(name, int'(seen), 1);
  endtask

  task automatic watch_handover(input int revert_at, output int hb_cnt, output int first_hb,
                                output int pause_lo, output int starts, output int hacks);
    hb_cnt = 0; first_hb = -1; pause_lo = 0; starts = 0; hacks = 0;
    for (int i = 0; i < 60; i++) begin
      if (i == revert_at) cur.pc = ~cur.pc;
      gen_sccb(1'b0);
      tick();
      if (bus.sccb_start) starts++;
      if (bus.hw_ack) hacks++;
      if (bus.handover_busy) begin
        if (first_hb < 0) first_hb = i;
        hb_cnt++;
        if (!bus.hw_pause) pause_lo++;
      end else if (hb_cnt > 0) begin
        break;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[10];
    int hb, fhb, plo, st, ha, pa, acks;

    tbl[0] = '{mk_in(0,0,8'h00,8'h00,1,8'h12,8'h80,0,0), mk_out(1,8'h12,8'h80,0,0,0,0,0)};
    tbl[1] = '{mk_in(0,0,8'h00,8'h00,1,8'h12,8'h80,1,0), mk_out(0,8'h12,8'h80,0,0,0,0,0)};
    tbl[2] = '{mk_in(0,0,8'h00,8'h00,1,8'h12,8'h80,1,0), mk_out(0,8'h12,8'h80,0,0,0,0,0)};
    tbl[3] = '{mk_in(0,0,8'h00,8'h00,1,8'h12,8'h80,0,1), mk_out(0,8'h12,8'h80,0,1,0,0,0)};
    tbl[4] = '{mk_in(0,0,8'h00,8'h00,1,8'h34,8'h56,0,0), mk_out(0,8'h12,8'h80,0,0,0,0,0)};
    tbl[5] = '{mk_in(0,0,8'h00,8'h00,1,8'h34,8'h56,0,0), mk_out(1,8'h34,8'h56,0,0,0,0,0)};
    tbl[6] = '{mk_in(0,1,8'h77,8'h88,0,8'h34,8'h56,1,0), mk_out(0,8'h34,8'h56,0,0,0,0,0)};
    tbl[7] = '{mk_in(0,1,8'h77,8'h88,0,8'h34,8'h56,0,1), mk_out(0,8'h34,8'h56,0,1,0,0,0)};
    tbl[8] = '{mk_in(0,1,8'h77,8'h88,0,8'h34,8'h56,0,1), mk_out(0,8'h34,8'h56,0,0,0,0,0)};
    tbl[9] = '{mk_in(0,1,8'h77,8'h88,0,8'h34,8'h56,0,0), mk_out(0,8'h34,8'h56,0,0,0,0,0)};

    cur = '0;
    apply();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_out("reset_state", dut_out(), '0);
    @(negedge clk);
    reset_n = 1'b1;

    // HW write path, ack blocking, spurious done, non-owner request.
    for (int k = 0; k < 10; k++) begin
      cur = tbl[k].i;
      tick();
      check_out($sformatf("t1_vec%0d", k), dut_out(), tbl[k].e);
    end
    cur = '0;
    tick();

    // Control pulsed high then back low: full settle, owner unchanged.
    cur.pc = 1'b1;
    watch_handover(3, hb, fhb, plo, st, ha);
    check_int("t4_busy_cycles", hb, SETTLE + 1);
    check_int("t4_owner", int'(bus.owner), 0);

    // Idle handover to processor.
    cur.pc = 1'b1;
    watch_handover(-1, hb, fhb, plo, st, ha);
    check_int("t2_drain_latency", fhb, 1);
    check_int("t2_busy_cycles", hb, SETTLE + 1);
    check_int("t2_pause_low", plo, 0);
    check_int("t2_owner", int'(bus.owner), 1);
    cur.proc_req = 1'b1; cur.proc_addr = 8'h3A; cur.proc_wdata = 8'h01;
    wait_start("t2_proc_start", 5);
    check_int("t2_proc_addr", int'(bus.sccb_addr), 8'h3A);
    check_int("t2_proc_wdata", int'(bus.sccb_wdata), 8'h01);
    cur.busy = 1'b1; tick();
    cur.busy = 1'b0; cur.done = 1'b1; tick();
    check_int("t2_proc_ack", int'(bus.proc_ack), 1);
    cur.done = 1'b0; cur.proc_req = 1'b0; tick();
    check_int("t2_proc_ack_pulse", int'(bus.proc_ack), 0);

    // Both requesters held with processor owning.
    cur.hw_req = 1'b1; cur.hw_addr = 8'hAA; cur.hw_wdata = 8'h55;
    sccb_rem = 0;
    run_auto(100, 1'b0, 1'b0, 1'b1, pa, ha);
    check_int("t5_hw_acks", ha, 0);
    check_int("t5_proc_served", int'(pa >= 2), 1);
    cur.proc_req = 1'b0;
    run_auto(10, 1'b0, 1'b0, 1'b0, pa, ha);
    check_int("t5_hw_acks_tail", ha, 0);
    cur.hw_req = 1'b0;
    cur.pc = 1'b0;
    watch_handover(-1, hb, fhb, plo, st, ha);
    check_int("t5_back_to_hw", int'(bus.owner), 0);

    // Flip while a HW write is in flight; the queued HW request must not issue.
    cur.hw_req = 1'b1; cur.hw_addr = 8'h5A; cur.hw_wdata = 8'hC3;
    cur.busy = 1'b0; cur.done = 1'b0;
    wait_start("t3_hw_start", 5);
    cur.pc = 1'b1;
    watch_handover(-1, hb, fhb, plo, st, ha);
    check_int("t3_extra_starts", st, 0);
    check_int("t3_hw_acks", ha, 1);
    check_int("t3_owner", int'(bus.owner), 1);
    st = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.sccb_start) st++;
    end
    check_int("t3_queued_hw_starts", st, 0);

    // Reset in the middle of a processor transaction.
    cur.hw_req = 1'b0;
    cur.proc_req = 1'b1; cur.proc_addr = 8'h66; cur.proc_wdata = 8'h99;
    wait_start("t6_proc_start", 5);
    cur.busy = 1'b1; tick();
    #3;
    reset_n = 1'b0;
    #1;
    check_out("t6_async_reset", dut_out(), '0);
    model_reset();
    cur = '0; cur.done = 1'b1;
    apply();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    sccb_rem = 0;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.proc_ack || bus.hw_ack) acks++;
      cur.done = 1'b0;
    end
    check_int("t6_no_ack_after_reset", acks, 0);

    // Random traffic with random control flips.
    run_auto(3000, 1'b1, 1'b1, 1'b1, pa, ha);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
